// File: rtl/register_file_rd.sv
// Eight-entry register file with two combinational, write-bypassed read ports and a
// handshaked sequencer that streams every stored register to a debug/trace consumer.
module register_file_rd #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend} dumpState_e;

    dumpState_e        stateQ, stateD;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] dumpAddrQ;
    logic [DATA_W-1:0] dumpDataQ;
    logic              lastBeat;

    // R0 is cleared on reset and never written, so it always holds zero.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (regWrite && (waddr != '0)) begin
            regs[waddr] <= din;
        end
    end

    always_comb begin
        dout_a = regs[raddr_a];
        if (raddr_a == '0) begin
            dout_a = '0;
        end else if (regWrite && (waddr == raddr_a)) begin
            dout_a = din;
        end
    end

    always_comb begin
        dout_b = regs[raddr_b];
        if (raddr_b == '0) begin
            dout_b = '0;
        end else if (regWrite && (waddr == raddr_b)) begin
            dout_b = din;
        end
    end

    assign lastBeat = (dumpAddrQ == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge CLK) begin
        if (!reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:  if (dump_start) stateD = StLoad;
            StLoad:  stateD = StSend;
            StSend:  if (dump_ready) stateD = lastBeat ? StIdle : StLoad;
            default: stateD = StIdle;
        endcase
    end

    // The beat is captured from stored contents only, so a same-cycle write is not seen.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            dumpAddrQ <= '0;
            dumpDataQ <= '0;
        end else begin
            if ((stateQ == StIdle) && dump_start) begin
                dumpAddrQ <= '0;
            end else if ((stateQ == StSend) && dump_ready && !lastBeat) begin
                dumpAddrQ <= dumpAddrQ + ADDR_W'(1);
            end
            if (stateQ == StLoad) begin
                dumpDataQ <= regs[dumpAddrQ];
            end
        end
    end

    always_comb begin
        dump_valid = (stateQ == StSend);
        dump_busy  = (stateQ != StIdle);
        dump_addr  = dumpAddrQ;
        dump_data  = dumpDataQ;
    end

endmodule

// File: tb/tb_register_file_rd.sv
// Scoreboard bench for register_file_rd: directed corner cases followed by random traffic,
// with dump beats checked by a separate monitor against a queue of expected beats.
module tb_register_file_rd;

    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
    } beat_t;

    logic        CLK = 1'b0;
    logic        reset;
    logic        regWrite;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] dout_a;
    logic [15:0] dout_b;
    logic        dump_start;
    logic        dump_ready;
    logic        dump_valid;
    logic [2:0]  dump_addr;
    logic [15:0] dump_data;
    logic        dump_busy;

    beat_t       expQ[$];
    int unsigned beatCyc[$];
    logic [15:0] model [8];
    int unsigned cyc = 0;
    int          nCompared = 0;
    int          nMismatched = 0;

    register_file_rd #(
        .NUM_REGS(8),
        .ADDR_W  (3),
        .DATA_W  (16)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .regWrite  (regWrite),
        .waddr     (waddr),
        .din       (din),
        .raddr_a   (raddr_a),
        .raddr_b   (raddr_b),
        .dout_a    (dout_a),
        .dout_b    (dout_b),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_busy (dump_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Architectural register contents: reset clears all, R0 never changes.
    always @(posedge CLK) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) model[i] <= 16'h0000;
        end else if (regWrite && (waddr != 3'd0)) begin
            model[waddr] <= din;
        end
    end

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [15:0] expRead(input logic [2:0] ra);
        if (ra == 3'd0) return 16'h0000;
        if (regWrite && (waddr == ra)) return din;
        return model[ra];
    endfunction

    // Monitor: every valid beat must match the head of the queue; a handshake retires it.
    always @(negedge CLK) begin
        if (dump_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("FAIL dump_extra: beat addr %0d data %h, required no beat", dump_addr,
                         dump_data);
            end else begin
                check("dump_addr", 32'(dump_addr), 32'(expQ[0].addr));
                check("dump_data", 32'(dump_data), 32'(expQ[0].data));
                if (dump_ready === 1'b1) begin
                    void'(expQ.pop_front());
                    beatCyc.push_back(cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkReads(input logic [2:0] ra, input logic [2:0] rb, input string nm);
        raddr_a = ra;
        raddr_b = rb;
        #1;
        check({nm, " dout_a"}, 32'(dout_a), 32'(expRead(ra)));
        check({nm, " dout_b"}, 32'(dout_b), 32'(expRead(rb)));
    endtask

    task automatic pushSnapshot();
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.addr = 3'(i);
            b.data = model[i];
            expQ.push_back(b);
        end
    endtask

    task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
        regWrite = 1'b1;
        waddr    = a;
        din      = d;
        step();
        regWrite = 1'b0;
    endtask

    task automatic startDump();
        bit idle;
        idle = (expQ.size() == 0);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        if (idle) pushSnapshot();
    endtask

    task automatic waitQueue(input int unsigned left, input int budget, input string nm);
        int k;
        k = 0;
        while ((expQ.size() != left) && (k < budget)) begin
            step();
            k++;
        end
        check({nm, " queue level"}, 32'(expQ.size()), 32'(left));
    endtask

    initial begin
        logic [15:0] vals [4];
        logic [2:0]  wa;
        bit          idle;
        bit          st;
        int unsigned c0;

        vals[0] = 16'h8000;
        vals[1] = 16'hFFFF;
        vals[2] = 16'h0000;
        vals[3] = 16'h7FFF;
        reset = 1'b0; regWrite = 1'b0; waddr = 3'd0; din = 16'h0000;
        raddr_a = 3'd0; raddr_b = 3'd0; dump_start = 1'b0; dump_ready = 1'b1;
        step();
        step();
        reset = 1'b1;
        check("reset dump_valid", 32'(dump_valid), 32'd0);
        check("reset dump_busy", 32'(dump_busy), 32'd0);
        check("reset dump_addr", 32'(dump_addr), 32'd0);
        check("reset dump_data", 32'(dump_data), 32'd0);

        // Reset clears a written register and wins over a concurrent write.
        writeReg(3'd3, 16'h1234);
        checkReads(3'd3, 3'd3, "R3 written");
        reset = 1'b0; regWrite = 1'b1; waddr = 3'd3; din = 16'h5555;
        step();
        reset = 1'b1; regWrite = 1'b0;
        checkReads(3'd3, 3'd3, "R3 after reset");
        check("R3 after reset literal", 32'(dout_a), 32'd0);
        check("post-reset dump_valid", 32'(dump_valid), 32'd0);
        check("post-reset dump_busy", 32'(dump_busy), 32'd0);

        for (int a = 1; a < 8; a++) begin
            writeReg(3'(a), vals[(a - 1) % 4]);
            checkReads(3'(a), 3'(a), "full range");
            check("full range literal", 32'(dout_b), 32'(vals[(a - 1) % 4]));
        end
        writeReg(3'd0, 16'h7FFF);
        checkReads(3'd0, 3'd0, "R0 write discarded");

        writeReg(3'd5, 16'h0001);
        regWrite = 1'b1; waddr = 3'd5; din = 16'hBEEF;
        checkReads(3'd5, 3'd5, "bypass R5");
        check("bypass R5 literal", 32'(dout_a), 32'h0000BEEF);
        step();
        waddr = 3'd0;
        checkReads(3'd0, 3'd0, "bypass R0");
        step();
        regWrite = 1'b0;

        // Full dump with ready tied high: one beat every two cycles.
        for (int i = 1; i < 8; i++) writeReg(3'(i), 16'(16'h0011 * i));
        beatCyc.delete();
        dump_ready = 1'b1;
        c0 = cyc;
        startDump();
        while (cyc < c0 + 16) step();
        check("dump busy during beat7", 32'(dump_busy), 32'd1);
        check("dump valid during beat7", 32'(dump_valid), 32'd1);
        step();
        check("dump busy after beat7", 32'(dump_busy), 32'd0);
        check("dump valid after beat7", 32'(dump_valid), 32'd0);
        check("dump beats delivered", 32'(beatCyc.size()), 32'd8);
        for (int i = 0; i < 8 && i < beatCyc.size(); i++) begin
            check("beat timing", beatCyc[i], c0 + 2 + 2 * i);
        end

        // Backpressure on beat 2 with a write to R2 and an ignored restart during the stall.
        startDump();
        waitQueue(6, 40, "reach beat2");
        dump_ready = 1'b0;
        step();
        writeReg(3'd2, 16'hAAAA);
        startDump();
        step();
        step();
        step();
        dump_ready = 1'b1;
        waitQueue(0, 40, "stall drain");
        step();
        check("restart ignored busy", 32'(dump_busy), 32'd0);
        startDump();
        check("second dump R2", 32'(expQ[2].data), 32'h0000AAAA);
        waitQueue(0, 40, "second dump drain");

        // Reset in the middle of beat 4.
        startDump();
        waitQueue(4, 40, "reach beat4");
        dump_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        expQ.delete();
        reset = 1'b1;
        check("mid-dump reset valid", 32'(dump_valid), 32'd0);
        check("mid-dump reset busy", 32'(dump_busy), 32'd0);
        for (int a = 0; a < 8; a++) begin
            checkReads(3'(a), 3'(a), "mid-dump reset regs");
            check("mid-dump reset literal", 32'(dout_a), 32'd0);
        end
        dump_ready = 1'b1;

        // Random traffic; during a dump, only registers already streamed may be rewritten.
        for (int n = 0; n < 600; n++) begin
            wa   = 3'($urandom_range(0, 7));
            idle = (expQ.size() == 0);
            regWrite = 1'($urandom_range(0, 1));
            if (!idle && (int'(wa) >= 8 - int'(expQ.size()))) regWrite = 1'b0;
            waddr      = wa;
            din        = 16'($urandom);
            dump_ready = ($urandom_range(0, 3) != 0);
            st         = ($urandom_range(0, 15) == 0);
            dump_start = st;
            checkReads(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), "random");
            step();
            if (idle && st) pushSnapshot();
        end
        dump_start = 1'b0;
        regWrite   = 1'b0;
        dump_ready = 1'b1;
        waitQueue(0, 60, "final drain");
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/register_file_rd.md
# register_file_rd

Eight-entry, 16-bit general-purpose register file for the datapath, with two same-cycle read ports, one write port, and write-to-read bypass. It also contains a handshaked dump sequencer. The sequencer reads every register in order and streams the values to a debug/trace consumer. It is the read side of the register write path: the pipeline writes registers through `regWrite`/`din`, and this block returns those values to the ALU operand muxes and to the dump interface.

## Interface
Parameters:
- NUM_REGS, 8: number of registers. Must be a power of two.
- ADDR_W, 3: address width, equal to log2(NUM_REGS).
- DATA_W, 16: register width. Values are two's-complement.

Ports:
- CLK  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of CLK.
- regWrite  in  1  write enable.
- waddr  in  ADDR_W  write address.
- din  in  DATA_W  write data.
- raddr_a  in  ADDR_W  read address, port A.
- raddr_b  in  ADDR_W  read address, port B.
- dout_a  out  DATA_W  read data, port A (combinational).
- dout_b  out  DATA_W  read data, port B (combinational).
- dump_start  in  1  request a full register dump.
- dump_ready  in  1  consumer accepts the current dump beat.
- dump_valid  out  1  dump beat present.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register value of the current beat.
- dump_busy  out  1  high whenever the sequencer is not in IDLE.

## Operation
- Storage: NUM_REGS × DATA_W flops.
- R0 is hardwired to 0. Writes to address 0 are discarded, and reads of address 0 return 0.
- Write: on the rising edge, if regWrite=1 and waddr≠0, reg[waddr] <= din.
- Read, per port, combinational:
  - If raddr=0, output 0.
  - Else if regWrite=1 and waddr=raddr, output din (bypass).
  - Else output reg[raddr].
- Both ports may read the same address. The bypass applies to each port independently.
- Dump FSM has three states: IDLE, LOAD, SEND.
  - IDLE: dump_valid=0. If dump_start=1, set dump_addr <= 0 and go to LOAD.
  - LOAD: dump_data <= reg[dump_addr], read from stored contents with no bypass. Go to SEND.
  - SEND: dump_valid=1. If dump_ready=1 and dump_addr=NUM_REGS-1, go to IDLE. If dump_ready=1 otherwise, dump_addr <= dump_addr+1 and go to LOAD. If dump_ready=0, stay in SEND.
- While dump_valid=1 and dump_ready=0, dump_addr and dump_data hold steady, even if the register they came from is written.
- dump_start is ignored outside IDLE.
- A dump does not stall or block normal reads or writes.
- dump_addr is ADDR_W bits wide and never wraps past NUM_REGS-1. The sequencer returns to IDLE instead.

## Timing
- Reset (reset=0 at an edge):
  - All registers become 0.
  - FSM goes to IDLE, and dump_addr, dump_data, and dump_valid become 0.
  - dump_busy becomes 0.
  - dout_a and dout_b read 0 once the registers are cleared, unless the bypass forwards din.
- Reset takes priority over a write in the same cycle.
- Reset mid-dump aborts the dump. dump_valid is 0 from the next cycle.
- Write-to-read latency:
  - 0 cycles through the bypass.
  - From the stored copy, visible starting the cycle after the edge.
- Dump latency:
  - dump_start is sampled at edge N.
  - LOAD occupies cycle N..N+1.
  - dump_valid=1 after edge N+1.
- Beat throughput is at most one beat per 2 cycles. A full dump with dump_ready tied high takes 2·NUM_REGS cycles, i.e. 16 cycles.
- dump_busy=1 from the edge after dump_start is accepted through the edge at which the final handshake completes.
- Write to reg[k] in the same cycle as LOAD for k: dump_data captures the old value.
- Write to reg[k] during SEND for k: not reflected in the beat.

## Test plan
- Reset behaviour:
  - Stimulus: write 0x1234 to R3, then reset=0 for 1 cycle.
  - Required: raddr_a=3 reads 0, dump_valid=0, dump_busy=0.
- R0 and full-range write/read:
  - Stimulus: write -32768, -1, 0, and 32767 to R1..R7.
  - Required: each value reads back on both ports the following cycle.
  - Stimulus: write 0x7FFF to R0.
  - Required: R0 reads 0.
- Bypass:
  - Stimulus: regWrite=1, waddr=5, din=0xBEEF, raddr_a=raddr_b=5, with R5 holding 0x0001.
  - Required: both ports output 0xBEEF in the same cycle.
  - Stimulus: same write with waddr=0.
  - Required: both ports read 0 when raddr_a=raddr_b=0.
- Dump with dump_ready tied high:
  - Preload: R1..R7 = 0x0011·i.
  - Stimulus: pulse dump_start.
  - Required: beats (0,0x0000), (1,0x0011) … (7,0x0077), one every 2 cycles; first dump_valid 2 edges after start; dump_busy falls after beat 7.
- Backpressure:
  - Stimulus: hold dump_ready=0 for 5 cycles on beat 2, and write R2=0xAAAA during the stall.
  - Required: dump_addr=2 and the pre-write dump_data held stable throughout the stall; a dump_start pulse issued mid-dump is ignored; a subsequent dump shows 0xAAAA.
- Reset mid-dump:
  - Stimulus: assert reset during beat 4.
  - Required: dump_valid=0 and dump_busy=0 the next cycle, and all registers read 0.
